// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state
// encoding, register offsets and STATUS word bit positions.
package uart_pkg;

    // Transmit FSM states; PARITY is only reachable when parity is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Register byte offsets from BASE_ADDR.
    localparam int TXDATA_OFS = 0;
    localparam int STATUS_OFS = 4;

    // STATUS word layout.
    localparam int STAT_IRQ       = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_BUSY      = 3;
    localparam int STAT_OVERFLOW  = 4;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised. Pointers carry
// one extra wrap bit so full and empty can be told apart without a counter.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers on accepted pops and pushes.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Write accepted data into the slot addressed by the write pointer.
    // NOTE: storage is deliberately not reset; the empty flag guarantees
    // stale entries are never read, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter. Stores to TXDATA queue bytes in a small
// FIFO; a bit-timing FSM sends them LSB first with one start and one stop
// bit. STATUS reports FIFO/busy/overflow state combinationally.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h0000_0100),
    parameter int                    DATA_BITS    = 8,
    parameter int                    CLKS_PER_BIT = 16,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  we,
    input  logic                  re,
    output logic [31:0]           rdata,
    output logic                  tx,
    output logic                  irq,
    input  logic                  ready_clr
);

    localparam int PW     = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [ADDR_WIDTH-1:0] TXDATA_ADDR = BASE_ADDR + ADDR_WIDTH'(TXDATA_OFS);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + ADDR_WIDTH'(STATUS_OFS);

    // Bus decode
    logic sel_txdata;
    logic sel_status;
    logic wr_txdata;

    // FIFO interface
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [PW-1:0]        fifo_count;

    // FSM state
    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 baud_last;
    logic                 bit_last;

    logic                 overflow_q;
    logic                 busy;
    logic [31:0]          status;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:DATA_BITS];

    assign sel_txdata = (addr == TXDATA_ADDR);
    assign sel_status = (addr == STATUS_ADDR);
    assign wr_txdata  = we && sel_txdata;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .wdata (wdata[DATA_BITS-1:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign bit_last  = (bit_idx_q == IDX_W'(DATA_BITS - 1));
    assign busy      = (state_q != IDLE);
    assign irq       = fifo_empty && !busy;

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    // Latch even parity of each byte as it leaves the FIFO.
    always_ff @(posedge clk) begin
        if (reset)         parity_q <= 1'b0;
        else if (fifo_pop) parity_q <= ^fifo_rdata;
    end
`endif

    // Register FSM state, baud counter, bit index and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state, FIFO pop and serial output decode.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        tx        = 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_idx_d = '0;
                    baud_d    = '0;
                    state_d   = START;
                end
            end

            START: begin
                tx = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            DATA: begin
                tx = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_last) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = parity_q;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif

            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        bit_idx_d = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Sticky overflow: a dropped write sets it and wins over a same-cycle clear.
    // A write to a full FIFO is not dropped when the FSM pops in that cycle.
    always_ff @(posedge clk) begin
        if (reset)                                     overflow_q <= 1'b0;
        else if (wr_txdata && fifo_full && !fifo_pop)  overflow_q <= 1'b1;
        else if (ready_clr)                            overflow_q <= 1'b0;
    end

    // Assemble the STATUS word; unused bits read as zero.
    always_comb begin
        status                          = '0;
        status[STAT_IRQ]                = irq;
        status[STAT_EMPTY]              = fifo_empty;
        status[STAT_FULL]               = fifo_full;
        status[STAT_BUSY]               = busy;
        status[STAT_OVERFLOW]           = overflow_q;
        status[STAT_COUNT_LSB +: PW]    = fifo_count;
    end

    assign rdata = (re && sel_status) ? status : 32'd0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Expected line waveforms come from a frame-level model (start, LSB-first
// data, optional even parity, stop); a sampling receiver decodes tx into
// bytes for end-to-end comparison. Honours UART_TX_PARITY_EN.
module tb_mmio_uart_tx;
    import uart_pkg::*;

    localparam int DB    = 8;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DB + 3;
`else
    localparam int NBITS = DB + 2;
`endif
    localparam int FLEN  = NBITS * CPB;
    localparam int MAXW  = 128;

    localparam logic [31:0] BASE      = 32'h0000_0100;
    localparam logic [31:0] STAT_ADDR = BASE + 32'd4;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;
    logic        ready_clr;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc       = 0;
    int unsigned rst_edges = 0;
    logic [DB:0] rx_q [$];

    mmio_uart_tx #(
        .ADDR_WIDTH   (32),
        .BASE_ADDR    (BASE),
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .rdata     (rdata),
        .tx        (tx),
        .irq       (irq),
        .ready_clr (ready_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) rst_edges <= rst_edges + 1;
    end

    // Expected line level c cycles into a frame carrying byte d.
    function automatic logic wave_bit(input logic [DB-1:0] d, input int c);
        int b;
        b = c / CPB;
        if (b == 0)  return 1'b0;
        if (b <= DB) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == DB + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Mid-bit sampling receiver; frames disturbed by reset are discarded.
    logic [DB-1:0] md;
    logic          mok;
    int unsigned   mr0;
    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                mr0 = rst_edges;
                mok = 1'b1;
                md  = '0;
                repeat (CPB / 2) @(negedge clk);
                if (tx !== 1'b0) mok = 1'b0;
                for (int b = 0; b < DB; b++) begin
                    repeat (CPB) @(negedge clk);
                    md[b] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                if (tx !== ^md) mok = 1'b0;
`endif
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) mok = 1'b0;
                repeat (CPB / 2 - 1) @(negedge clk);
                if (rst_edges == mr0) rx_q.push_back({mok, md});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Drive one bus store; returns at the negedge after the store edge.
    task automatic write_word(input logic [31:0] a, input logic [DB-1:0] d, input logic clr);
        addr          = a;
        wdata         = $urandom();
        wdata[DB-1:0] = d;
        we            = 1'b1;
        re            = 1'b0;
        ready_clr     = clr;
        @(negedge clk);
        we        = 1'b0;
        ready_clr = 1'b0;
        addr      = '0;
    endtask

    task automatic read_status(output logic [31:0] v);
        addr = STAT_ADDR;
        re   = 1'b1;
        #1;
        v = rdata;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL wait_idle: irq=%b after %0d cycles, expected 1", irq, n);
        end
    endtask

    // Record tx, STATUS.busy and irq for n cycles starting at the current negedge.
    task automatic capture(input int n, output logic [MAXW-1:0] wt,
                           output logic [MAXW-1:0] wb, output logic [MAXW-1:0] wi);
        wt = '0;
        wb = '0;
        wi = '0;
        addr = STAT_ADDR;
        re   = 1'b1;
        #1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            wt[i] = tx;
            wb[i] = rdata[STAT_BUSY];
            wi[i] = irq;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; ready_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL reset_irq: got %b expected 1", irq); end
        addr = STAT_ADDR; re = 1'b0; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL rdata_no_re: got %h expected 0", rdata); end
        read_status(v);
        checks++;
        if (v !== 32'h0000_0003) begin failures++; $display("FAIL reset_status: got %h expected 00000003", v); end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        logic        saw_low;
        write_word(BASE + 32'd8, 8'($urandom()), 1'b0);
        write_word(STAT_ADDR, 8'($urandom()), 1'b0);
        read_status(v);
        checks++;
        if (v !== 32'h0000_0003) begin failures++; $display("FAIL decode_ignored_writes: status %h expected 00000003", v); end
        saw_low = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low !== 1'b0) begin failures++; $display("FAIL decode_tx_idle: tx left idle level, expected steady 1"); end
        addr = BASE; re = 1'b1; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL txdata_read: got %h expected 0", rdata); end
        addr = BASE + 32'd8; #1;
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL other_read: got %h expected 0", rdata); end
        re = 1'b0; addr = '0;
    endtask

    task automatic test_single(input logic [DB-1:0] d);
        logic [31:0]     v;
        logic [MAXW-1:0] wt, wb, wi, et, eb;
        rx_q.delete();
        write_word(BASE, d, 1'b0);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL single_latency: tx=%b one edge after push, expected 1", tx); end
        read_status(v);
        checks++;
        if (v !== 32'h0000_0100) begin failures++; $display("FAIL single_status_push: got %h expected 00000100", v); end
        @(negedge clk);
        capture(FLEN, wt, wb, wi);
        et = '0;
        eb = '0;
        for (int i = 0; i < FLEN; i++) begin
            et[i] = wave_bit(d, i);
            eb[i] = 1'b1;
        end
        checks++;
        if (wt !== et) begin failures++; $display("FAIL single_wave d=%h: got %h expected %h", d, wt, et); end
        checks++;
        if (wb !== eb) begin failures++; $display("FAIL single_busy d=%h: got %h expected %h", d, wb, eb); end
        checks++;
        if (wi !== '0) begin failures++; $display("FAIL single_irq_frame d=%h: got %h expected 0", d, wi); end
        @(negedge clk);
        read_status(v);
        checks++;
        if (v !== 32'h0000_0003 || tx !== 1'b1) begin
            failures++; $display("FAIL single_end d=%h: status %h tx %b expected 00000003 and 1", d, v, tx);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== {1'b1, d}) begin
            failures++; $display("FAIL single_rx d=%h: got %0d frames, first %h", d, rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : '0);
        end
    endtask

    task automatic test_back_to_back(input logic [DB-1:0] a, input logic [DB-1:0] b);
        logic [31:0]     v;
        logic [MAXW-1:0] wt, wb, wi, et, eb;
        rx_q.delete();
        write_word(BASE, a, 1'b0);
        write_word(BASE, b, 1'b0);
        capture(2 * FLEN, wt, wb, wi);
        et = '0;
        eb = '0;
        for (int i = 0; i < 2 * FLEN; i++) begin
            et[i] = (i < FLEN) ? wave_bit(a, i) : wave_bit(b, i - FLEN);
            eb[i] = 1'b1;
        end
        checks++;
        if (wt !== et) begin failures++; $display("FAIL b2b_wave %h,%h: got %h expected %h", a, b, wt, et); end
        checks++;
        if (wb !== eb) begin failures++; $display("FAIL b2b_busy %h,%h: got %h expected %h", a, b, wb, eb); end
        @(negedge clk);
        read_status(v);
        checks++;
        if (v !== 32'h0000_0003) begin failures++; $display("FAIL b2b_end: status %h expected 00000003", v); end
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== {1'b1, a} || rx_q[1] !== {1'b1, b}) begin
            failures++; $display("FAIL b2b_rx: got %0d frames, expected %h then %h", rx_q.size(), a, b);
        end
    endtask

    task automatic test_overflow();
        logic [31:0]   v;
        logic [DB-1:0] xs [7];
        logic [DB-1:0] xe;
        logic [DB-1:0] exp_q [$];
        int unsigned   c2;
        rx_q.delete();
        for (int i = 0; i < 7; i++) xs[i] = 8'($urandom());
        xe = 8'($urandom());
        write_word(BASE, xs[0], 1'b0);
        write_word(BASE, xs[1], 1'b0);
        c2 = cyc;
        for (int i = 2; i <= 5; i++) write_word(BASE, xs[i], 1'b0);
        read_status(v);
        checks++;
        if (v !== 32'h0000_041C) begin failures++; $display("FAIL ovf_set: status %h expected 0000041c", v); end
        write_word(BASE, xs[6], 1'b1);
        read_status(v);
        checks++;
        if (v !== 32'h0000_041C) begin failures++; $display("FAIL ovf_set_wins_clr: status %h expected 0000041c", v); end
        ready_clr = 1'b1;
        @(negedge clk);
        ready_clr = 1'b0;
        read_status(v);
        checks++;
        if (v !== 32'h0000_040C) begin failures++; $display("FAIL ovf_clear: status %h expected 0000040c", v); end
        // Store exactly on the edge where the first frame's stop bit ends.
        while (cyc < c2 + FLEN - 1) @(negedge clk);
        write_word(BASE, xe, 1'b0);
        read_status(v);
        checks++;
        if (v !== 32'h0000_040C) begin failures++; $display("FAIL full_push_with_pop: status %h expected 0000040c", v); end
        re = 1'b0;
        wait_idle(8 * FLEN);
        exp_q = '{xs[0], xs[1], xs[2], xs[3], xs[4], xe};
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            failures++; $display("FAIL ovf_frame_count: got %0d expected %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== {1'b1, exp_q[i]}) begin
                failures++; $display("FAIL ovf_frame_%0d: got %h expected %h", i, rx_q[i], {1'b1, exp_q[i]});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0]   v;
        logic [DB-1:0] d0, d1;
        logic          saw_low;
        rx_q.delete();
        d0    = 8'($urandom());
        d0[0] = 1'b0;
        d1    = 8'($urandom());
        write_word(BASE, d0, 1'b0);
        write_word(BASE, d1, 1'b0);
        repeat (CPB + 1) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL mid_data_bit: tx %b expected 0", tx); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx: got %b expected 1", tx); end
        read_status(v);
        checks++;
        if (v !== 32'h0000_0003) begin failures++; $display("FAIL mid_reset_status: got %h expected 00000003", v); end
        reset = 1'b0;
        re    = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 3 * FLEN; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low !== 1'b0) begin failures++; $display("FAIL mid_no_restart: tx went low after reset, expected steady 1"); end
        checks++;
        if (rx_q.size() != 0) begin failures++; $display("FAIL mid_rx: got %0d frames expected 0", rx_q.size()); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_single(8'hA5);
        test_single(8'h07);
        for (int i = 0; i < 3; i++) test_single(8'($urandom()));
        test_back_to_back(8'h55, 8'h0F);
        test_back_to_back(8'($urandom()), 8'($urandom()));
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped, parametrised UART transmitter peripheral for the single-cycle RISC-V core's data bus.
- Core stores to TXDATA push bytes into an internal FIFO; a bit-timing FSM serialises them onto `tx` (LSB first, 1 start, 1 stop).
- Loads from STATUS return FIFO and busy flags, so firmware can poll without stalling the single-cycle pipeline.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- BASE_ADDR, 32'h0000_0100, word address of TXDATA; STATUS is at BASE_ADDR+4.
- DATA_BITS, 8, payload bits per frame (5..9).
- CLKS_PER_BIT, 16, clock cycles per serial bit (>=2).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  ADDR_WIDTH  bus byte address
- wdata  in  32  store data; bits [DATA_BITS-1:0] used
- we  in  1  store strobe, sampled on rising clk
- re  in  1  load strobe (combinational read)
- rdata  out  32  load data; 0 when not selected
- tx  out  1  serial output, idle high
- irq  out  1  level interrupt: FIFO empty and FSM idle
- ready_clr  in  1  clears sticky `overflow` flag

Behaviour:
- One clock; reset is synchronous and active-high (ports `clk`, `reset`).
- Reset (next rising edge with reset=1):
  - FSM to IDLE; FIFO emptied; baud counter and bit index to 0.
  - Sticky overflow to 0; tx=1; irq=1.
  - Reset mid-frame aborts the frame immediately; tx returns high on the same edge.
- Write to TXDATA (we=1, addr==BASE_ADDR):
  - FIFO not full: push wdata[DATA_BITS-1:0] at that edge.
  - FIFO full: data dropped; overflow set to 1 (sticky).
- STATUS read (re=1, addr==BASE_ADDR+4), combinational same cycle:
  - rdata = {.., count[bit 8+:], overflow[4], busy[3], full[2], empty[1], irq[0]}.
  - count occupies [15:8], zero-extended.
- TXDATA read returns 0. Any other address: rdata=0, writes ignored.
- ready_clr=1 clears overflow at the next edge.
  - If ready_clr and an overflowing write occur in the same cycle, overflow ends at 1 (set wins).
- FSM states:
  - IDLE: tx=1. If FIFO non-empty, pop the head into shift register and go to START next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right; after DATA_BITS bits go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap); else IDLE.
- Latency: write into an empty FIFO with FSM idle → start bit appears on tx 2 edges later (push edge, then pop edge).
- Frame length: (DATA_BITS+2)*CLKS_PER_BIT cycles.
- busy=1 in every state except IDLE.
- Simultaneous push and pop in one cycle is legal; count stays unchanged.
- Push when full and pop in the same cycle: the pop frees the slot first, so the push succeeds with no overflow.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are decoded from the MSB difference.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state change.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP; tx = XOR of the data bits (even parity) for CLKS_PER_BIT cycles; frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined: no PARITY state; frames as above.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Register offsets TXDATA_OFS=0, STATUS_OFS=4.
  - STATUS bit-position constants.
- Sub-module uart_tx_fifo: synchronous FIFO parametrised by width/depth, with push, pop, full, empty, count. Instantiated once.

Test Plan:
- Reset behaviour, CLKS_PER_BIT=4: hold reset 2 cycles → tx=1, irq=1, STATUS read = 32'h0000_0003 (empty, irq).
- Single byte: store 8'hA5 to BASE_ADDR → start bit 2 edges later; tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles wide; irq=1 again after 40 cycles.
- Back-to-back: store 8'h55 then 8'h0F on consecutive cycles → two frames with no idle cycle between stop and start; busy=1 for 80 consecutive cycles.
- Overflow: FSM busy, push 5 bytes with FIFO_DEPTH=4 → STATUS overflow=1 and count=4; pulse ready_clr → overflow=0; only 4 frames are emitted after the in-flight one.
- Reset mid-frame: assert reset during the DATA state → tx=1 the next cycle, FIFO empty, no further start bits.
- UART_TX_PARITY_EN defined: send 8'h07 → parity bit=1 before stop; frame = 44 cycles at CLKS_PER_BIT=4.
